vga_dac_out: RTL and testbench

Final output stage of the video subsystem: takes the 8-bit palette colour and the hsync/vsync produced by the `video` block and drives the 4:4:4 VGA DAC pins. It widens the colour to 4 bits per channel and keeps syncs and colour aligned through a fixed 2-cycle pipeline. It holds the picture black for a programmable number of frames after reset or re-enable, so the monitor locks before pixels appear. An optional scanline-dimming effect can be compiled in.

---
 rtl/vga_dac_out.sv | 148 ++++++++++++++
 tb/tb_vga_dac_out.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_dac_out.sv
// VGA DAC output stage: widens 8-bit palette colour to 4:4:4 through a fixed 2-cycle pipeline, blanking for a settle period.
// Optional scanline dimming is compiled in when VGA_SCANLINE_DIM_EN is defined.
module vga_dac_out #(
    parameter int unsigned SETTLE_FRAMES = 2
) (
    input  logic       clk24,
    input  logic       reset_n,
    input  logic       video_en,
    input  logic       scanline_on,
    input  logic [7:0] realcolor,
    input  logic       hsync_in,
    input  logic       vsync_in,
    output logic [3:0] vga_r,
    output logic [3:0] vga_g,
    output logic [3:0] vga_b,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       running
);
    typedef enum logic [1:0] {BLANK, SETTLE, RUN} state_t;
    localparam logic [3:0] SETTLE_N = 4'(SETTLE_FRAMES);

    state_t     state;
    logic [3:0] frame_cnt;
    logic [3:0] frame_cnt_inc;
    logic [7:0] s1_color;
    logic       s1_hs;
    logic       s1_vs;
    logic       vs_fall;
    logic [3:0] r_exp, g_exp, b_exp;
    logic [3:0] r_px, g_px, b_px;

    // NOTE: reset is sampled inside the clocked block, so it only takes effect on a rising edge.
    always_ff @(posedge clk24) begin
        if (!reset_n) begin
            s1_color <= '0;
            s1_hs    <= 1'b1;
            s1_vs    <= 1'b1;
        end else begin
            s1_color <= realcolor;
            s1_hs    <= hsync_in;
            s1_vs    <= vsync_in;
        end
    end

    // The stage-2 syncs hold the previous stage-1 sample, so they double as edge-detect history.
    assign vs_fall       = vga_vs & ~s1_vs;
    assign frame_cnt_inc = (frame_cnt == 4'hF) ? 4'hF : frame_cnt + 4'd1;

    assign r_exp = {s1_color[2:0], s1_color[2]};
    assign g_exp = {s1_color[5:3], s1_color[5]};
    assign b_exp = {s1_color[7:6], s1_color[7:6]};

`ifdef VGA_SCANLINE_DIM_EN
    logic s1_scan;
    logic parity;
    logic hs_fall;
    logic dim;

    assign hs_fall = vga_hs & ~s1_hs;
    assign dim     = s1_scan & parity & (state == RUN);

    // Parity restarts at every frame so the first line after vsync is always even.
    always_ff @(posedge clk24) begin
        if (!reset_n) begin
            s1_scan <= 1'b0;
            parity  <= 1'b0;
        end else begin
            s1_scan <= scanline_on;
            if (vs_fall)
                parity <= 1'b0;
            else if (hs_fall)
                parity <= ~parity;
        end
    end

    assign r_px = dim ? (r_exp >> 1) : r_exp;
    assign g_px = dim ? (g_exp >> 1) : g_exp;
    assign b_px = dim ? (b_exp >> 1) : b_exp;
`else
    logic unused_scanline;
    assign unused_scanline = scanline_on;

    assign r_px = r_exp;
    assign g_px = g_exp;
    assign b_px = b_exp;
`endif

    always_ff @(posedge clk24) begin
        if (!reset_n) begin
            state     <= BLANK;
            frame_cnt <= 4'd0;
            running   <= 1'b0;
        end else if (!video_en) begin
            state     <= BLANK;
            frame_cnt <= 4'd0;
            running   <= 1'b0;
        end else begin
            case (state)
                BLANK: begin
                    if (vs_fall) begin
                        state     <= SETTLE;
                        frame_cnt <= 4'd0;
                    end
                end
                SETTLE: begin
                    if (vs_fall) begin
                        frame_cnt <= frame_cnt_inc;
                        if (frame_cnt_inc == SETTLE_N) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    running <= 1'b1;
                end
                default: begin
                    state   <= BLANK;
                    running <= 1'b0;
                end
            endcase
        end
    end

    // Syncs always pass through; only colour is gated by the settle state.
    always_ff @(posedge clk24) begin
        if (!reset_n) begin
            vga_r  <= 4'd0;
            vga_g  <= 4'd0;
            vga_b  <= 4'd0;
            vga_hs <= 1'b1;
            vga_vs <= 1'b1;
        end else begin
            vga_hs <= s1_hs;
            vga_vs <= s1_vs;
            if (state == RUN) begin
                vga_r <= r_px;
                vga_g <= g_px;
                vga_b <= b_px;
            end else begin
                vga_r <= 4'd0;
                vga_g <= 4'd0;
                vga_b <= 4'd0;
            end
        end
    end
endmodule

// File: tb/tb_vga_dac_out.sv
// Self-checking bench for vga_dac_out: colour expansion table, settle sequence, enable drop, reset, sync delay.
// Dimming expectations follow VGA_SCANLINE_DIM_EN when it is defined for the build.
module tb_vga_dac_out;
    logic       clk24 = 1'b0;
    logic       reset_n;
    logic       video_en;
    logic       scanline_on;
    logic [7:0] realcolor;
    logic       hsync_in;
    logic       vsync_in;
    logic [3:0] vga_r, vga_g, vga_b;
    logic       vga_hs, vga_vs;
    logic       running;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference pipeline for the syncs: value in stage 1 and value on the pins.
    logic m_s1_hs = 1'b1, m_hs = 1'b1;
    logic m_s1_vs = 1'b1, m_vs = 1'b1;

`ifdef VGA_SCANLINE_DIM_EN
    localparam logic [3:0] ODD_LVL = 4'h7;
`else
    localparam logic [3:0] ODD_LVL = 4'hF;
`endif

    typedef struct {
        logic [7:0] color;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } vec_t;

    vec_t vecs[6];

    vga_dac_out #(.SETTLE_FRAMES(2)) dut (
        .clk24      (clk24),
        .reset_n    (reset_n),
        .video_en   (video_en),
        .scanline_on(scanline_on),
        .realcolor  (realcolor),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .vga_r      (vga_r),
        .vga_g      (vga_g),
        .vga_b      (vga_b),
        .vga_hs     (vga_hs),
        .vga_vs     (vga_vs),
        .running    (running)
    );

    always #5 clk24 = ~clk24;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_rgb(input string name, input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
        check({name, "_r"}, vga_r, r);
        check({name, "_g"}, vga_g, g);
        check({name, "_b"}, vga_b, b);
    endtask

    // One rising edge, then compare the syncs against the 2-deep reference delay.
    task automatic step();
        logic hs_now, vs_now, rst_now;
        hs_now  = hsync_in;
        vs_now  = vsync_in;
        rst_now = reset_n;
        @(posedge clk24);
        if (!rst_now) begin
            m_s1_hs = 1'b1; m_hs = 1'b1;
            m_s1_vs = 1'b1; m_vs = 1'b1;
        end else begin
            m_hs = m_s1_hs; m_s1_hs = hs_now;
            m_vs = m_s1_vs; m_s1_vs = vs_now;
        end
        #1;
        check("hs_delay", vga_hs, m_hs);
        check("vs_delay", vga_vs, m_vs);
    endtask

    task automatic vs_pulse();
        vsync_in = 1'b0;
        step();
        step();
        vsync_in = 1'b1;
        repeat (4) step();
    endtask

    task automatic hs_pulse(input logic with_vs);
        hsync_in = 1'b0;
        if (with_vs) vsync_in = 1'b0;
        step();
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        step();
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'hFF,        4'hF, 4'hF, 4'hF};
        vecs[1] = '{8'h00,        4'h0, 4'h0, 4'h0};
        vecs[2] = '{8'b10_101_011, 4'h6, 4'hB, 4'hA};
        vecs[3] = '{8'b01_010_100, 4'h9, 4'h4, 4'h5};
        vecs[4] = '{8'b00_001_110, 4'hD, 4'h2, 4'h0};
        vecs[5] = '{8'b11_100_001, 4'h2, 4'h9, 4'hF};

        reset_n     = 1'b0;
        video_en    = 1'b1;
        scanline_on = 1'b0;
        realcolor   = 8'hFF;
        hsync_in    = 1'b1;
        vsync_in    = 1'b1;
        step();
        step();
        check_rgb("reset", 4'h0, 4'h0, 4'h0);
        check("reset_running", running, 1'b0);
        reset_n = 1'b1;

        // No vsync: colour must stay black while hsync toggles through.
        for (int i = 0; i < 1000; i++) begin
            hsync_in = (i % 50) >= 45 ? 1'b0 : 1'b1;
            step();
            check_rgb("blank_hold", 4'h0, 4'h0, 4'h0);
            check("blank_running", running, 1'b0);
        end
        hsync_in = 1'b1;
        step();

        // Settle: first pulse enters SETTLE, two more reach RUN.
        realcolor = 8'b10_101_011;
        vs_pulse();
        vs_pulse();
        check("settle_running", running, 1'b0);
        check_rgb("settle_black", 4'h0, 4'h0, 4'h0);
        vsync_in = 1'b0;
        step();
        check("run_not_yet", running, 1'b0);
        step();
        check("run_rise", running, 1'b1);
        check_rgb("run_first_black", 4'h0, 4'h0, 4'h0);
        vsync_in = 1'b1;
        step();
        check_rgb("run_first_pixel", 4'h6, 4'hB, 4'hA);

        foreach (vecs[i]) begin
            realcolor = vecs[i].color;
            step();
            step();
            check_rgb("expand", vecs[i].r, vecs[i].g, vecs[i].b);
        end

        // Scanline parity: even line full, odd line dimmed, vsync+hsync resets to even.
        realcolor   = 8'hFF;
        scanline_on = 1'b1;
        step();
        step();
        check_rgb("line_even0", 4'hF, 4'hF, 4'hF);
        hs_pulse(1'b0);
        check_rgb("line_odd1", ODD_LVL, ODD_LVL, ODD_LVL);
        hs_pulse(1'b0);
        check_rgb("line_even2", 4'hF, 4'hF, 4'hF);
        hs_pulse(1'b0);
        check_rgb("line_odd3", ODD_LVL, ODD_LVL, ODD_LVL);
        hs_pulse(1'b1);
        check_rgb("vs_hs_even", 4'hF, 4'hF, 4'hF);
        check("vs_in_run", running, 1'b1);
        scanline_on = 1'b0;
        step();

        // video_en low for one cycle: black two edges later and a full settle to recover.
        video_en = 1'b0;
        step();
        check("en_drop_running", running, 1'b0);
        check_rgb("en_drop_inflight", 4'hF, 4'hF, 4'hF);
        video_en = 1'b1;
        step();
        check_rgb("en_drop_black", 4'h0, 4'h0, 4'h0);

        // vs_fall coincident with video_en low must not start the settle sequence.
        vsync_in = 1'b0;
        step();
        video_en = 1'b0;
        step();
        video_en = 1'b1;
        vsync_in = 1'b1;
        repeat (4) step();
        vs_pulse();
        vs_pulse();
        check("blank_wins_running", running, 1'b0);
        check_rgb("blank_wins_black", 4'h0, 4'h0, 4'h0);
        vs_pulse();
        check("resettle_running", running, 1'b1);
        check_rgb("resettle_pixel", 4'hF, 4'hF, 4'hF);

        // Reset mid-line in RUN, with hsync low in flight.
        hsync_in = 1'b0;
        step();
        reset_n = 1'b0;
        step();
        check_rgb("midreset", 4'h0, 4'h0, 4'h0);
        check("midreset_running", running, 1'b0);
        check("midreset_hs", vga_hs, 1'b1);
        check("midreset_vs", vga_vs, 1'b1);
        reset_n  = 1'b1;
        hsync_in = 1'b1;
        step();
        step();
        check_rgb("after_reset_black", 4'h0, 4'h0, 4'h0);
        vs_pulse();
        check("after_reset_running", running, 1'b0);

        // Random sync and colour stream; the step task checks the 2-cycle sync delay.
        for (int i = 0; i < 400; i++) begin
            hsync_in  = 1'($urandom_range(0, 1));
            vsync_in  = ($urandom_range(0, 7) == 0) ? 1'b0 : 1'b1;
            realcolor = 8'($urandom);
            video_en  = ($urandom_range(0, 31) == 0) ? 1'b0 : 1'b1;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
